stack_seq_ctrl: RTL and testbench
=================================

// Module: stack_seq_ctrl
// PURPOSE
//  Parametrised multi-register stack sequencer: executes PUSH/POP of a register list plus
//  SP adjust/load ops for the datapath. Owns the stack pointer; checks stack bounds before
//  any memory access. Drives RF/dmem control per transfer beat; handshakes with dmem (mem_ack).
//  Sits between decode (start/op) and the RF/dmem muxes; mem_force steers dmem address to it.
// PARAMETERS
//  ADDR_W     16      SP / dmem address width (bytes)
//  REG_AW     3       RF address width; NREG = 2**REG_AW low registers in reg_list
//  WB_LOG2    2       log2(bytes per word); WB = 2**WB_LOG2
//  SP_TOP     16'h0100  reset SP and highest legal SP (empty stack)
//  SP_LIMIT   16'h0000  lowest legal SP (full stack)
// PORTS
//  clk         in   1         clock, rising edge
//  resetn      in   1         asynchronous, active-low reset
//  start       in   1         op request; sampled only in IDLE
//  op          in   3         0 PUSH, 1 POP, 2 ADDSP, 3 SUBSP, 4 SETSP; others -> fault
//  reg_list    in   NREG+1    bit i = Ri; bit NREG = LR (PUSH) / PC (POP); held stable until done
//  imm         in   ADDR_W    byte offset (ADDSP/SUBSP) or new SP (SETSP)
//  mem_ack     in   1         dmem completes current beat this cycle
//  busy        out  1         high from accepted start until the cycle after done
//  done        out  1         one-cycle completion pulse
//  fault       out  1         valid with done: bound/alignment/illegal-op violation
//  rdest_addr  out  REG_AW    RF register for current beat
//  LR_sel      out  1         PUSH beat sources LR instead of RF
//  dmem_addr   out  ADDR_W    beat address
//  mem_force   out  1         dmem address/data owned by this block (high in XFER)
//  dmem_wr     out  1         PUSH beat write strobe
//  dmem_rd     out  1         POP beat read strobe
//  RF_wr       out  1         POP beat writes rdest_addr (qualified by mem_ack)
//  PC_wr       out  1         POP beat of bit NREG writes PC (qualified by mem_ack)
//  SP_out      out  ADDR_W    current SP
// BEHAVIOUR
//  Reset: state IDLE, SP=SP_TOP, all strobes/done/fault/busy 0, rdest_addr/dmem_addr 0.
//  FSM: IDLE -start-> CHECK (PUSH/POP) or DONE (others); CHECK -ok,N>0-> XFER; CHECK -fault
//   or N=0-> DONE; XFER -last beat acked-> DONE; DONE -> IDLE. start ignored outside IDLE.
//  N = popcount(reg_list), computed in CHECK. Arithmetic in ADDR_W+1 bits; carry/borrow = fault.
//  PUSH (full-descending): SPn = SP - N*WB; fault if borrow or SPn < SP_LIMIT. Beat k (k-th set
//   bit, ascending index) writes dmem_addr = SPn + k*WB; bit NREG (LR) is last/highest.
//  POP: SPn = SP + N*WB; fault if carry or SPn > SP_TOP. Beat k reads SP + k*WB into k-th set
//   bit ascending; bit NREG -> PC_wr, others -> RF_wr with rdest_addr = index.
//  Beat held (addr/strobes stable) until mem_ack; advance on ack; one beat min per cycle.
//  ADDSP: SP+imm; SUBSP: SP-imm; SETSP: imm. Fault if imm[WB_LOG2-1:0]!=0, carry/borrow,
//   or result outside [SP_LIMIT, SP_TOP].
//  SP commits only on the edge entering DONE, only if no fault; SP_out shows new value with done.
//  Fault: no dmem/RF/PC strobes issued at all; SP unchanged; done=fault=1 for one cycle.
//  N=0 PUSH/POP: no beats, done 2 cycles after start, SP unchanged, no fault.
//  Reset mid-XFER: abort immediately, SP=SP_TOP; beats already acked are not undone.
//  Latency PUSH/POP: 1 (CHECK) + sum of beat cycles + 1 (DONE); SP ops: done cycle after start.
// TESTING
//  PUSH {R0,R2,LR}, SP=0x100, mem_ack=1 -> writes R0@0xF4, R2@0xF8, LR@0xFC (LR_sel); done at
//   cycle 5; SP_out=0xF4.
//  POP {R0,R2,PC} from SP=0xF4 -> RF_wr R0<-[0xF4], R2<-[0xF8], PC_wr<-[0xFC]; SP_out=0x100.
//  SP_LIMIT=0xF0, SP=0xF4, PUSH {R1,R3} -> fault with done at cycle 2, no dmem_wr, SP=0xF4.
//  PUSH {R5}, mem_ack low 3 cycles -> dmem_wr/addr 0xFC held 4 cycles; done one cycle after ack.
//  SUBSP imm=0x6 -> misaligned fault; SETSP imm=0x200 -> bound fault; SETSP 0x80 -> SP_out=0x80.
//  resetn low during 2nd beat of 4-reg PUSH -> all outputs 0, SP_out=0x100, busy 0.

Source files
------------

// File: rtl/stack_seq_ctrl.sv
// stack_seq_ctrl: multi-register PUSH/POP and SP adjust/load sequencer.
// Owns the stack pointer, bounds-checks every stack operation before any
// memory beat is issued, and drives RF/dmem control one beat at a time.
module stack_seq_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter int                REG_AW   = 3,
    parameter int                WB_LOG2  = 2,
    parameter logic [ADDR_W-1:0] SP_TOP   = 16'h0100,
    parameter logic [ADDR_W-1:0] SP_LIMIT = 16'h0000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [2**REG_AW:0]  reg_list,
    input  logic [ADDR_W-1:0]   imm,
    input  logic                mem_ack,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [REG_AW-1:0]   rdest_addr,
    output logic                LR_sel,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic                mem_force,
    output logic                dmem_wr,
    output logic                dmem_rd,
    output logic                RF_wr,
    output logic                PC_wr,
    output logic [ADDR_W-1:0]   SP_out
);

    localparam int NREG = 2**REG_AW;
    localparam int LW   = NREG + 1;
    localparam int IW   = $clog2(LW);
    localparam int CW   = $clog2(LW + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] OP_PUSH  = 3'd0;
    localparam logic [2:0] OP_POP   = 3'd1;
    localparam logic [2:0] OP_ADDSP = 3'd2;
    localparam logic [2:0] OP_SUBSP = 3'd3;
    localparam logic [2:0] OP_SETSP = 3'd4;

    localparam logic [IW-1:0]   LR_IDX = IW'(NREG);
    localparam logic [ADDR_W-1:0] WB_A = {{(ADDR_W-1){1'b0}}, 1'b1} << WB_LOG2;

    // Number of registers selected in a list.
    function automatic logic [CW-1:0] popcnt(input logic [LW-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < LW; i++) begin
            c = c + {{(CW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Index of the lowest set bit (beats go in ascending register order).
    function automatic logic [IW-1:0] lowest(input logic [LW-1:0] v);
        logic [IW-1:0] r;
        r = {IW{1'b0}};
        for (int i = LW - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IW'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [1:0]        state_r, state_s;
    logic [ADDR_W-1:0] sp_r, sp_s, spn_r, spn_s;
    logic [LW-1:0]     mask_r, mask_s, rem_s;
    logic [IW-1:0]     cur_r, beat_idx_s;
    logic              pop_r, pop_s;
    logic              done_s, fault_s, beat_on_s, is_lr_s;
    logic [ADDR_W-1:0] addr_s;
    logic [REG_AW-1:0] rdest_s;

    logic [CW-1:0]     cnt_s;
    logic [ADDR_W:0]   sp_x_s, bytes_s, push_diff_s, pop_sum_s, spop_res_s;
    logic              chk_fault_s, spop_fault_s;

    logic              busy_r, done_r, fault_r, force_r, wr_r, rd_r;
    logic              lr_r, rfw_r, pcw_r;
    logic [ADDR_W-1:0] addr_r;
    logic [REG_AW-1:0] rdest_r;

    // Bound arithmetic for stack transfers and SP ops, one extra bit for carry/borrow.
    always_comb begin
        cnt_s       = popcnt(reg_list);
        sp_x_s      = {1'b0, sp_r};
        bytes_s     = {{(ADDR_W+1-CW){1'b0}}, cnt_s} << WB_LOG2;
        push_diff_s = sp_x_s - bytes_s;
        pop_sum_s   = sp_x_s + bytes_s;
        if (pop_r) begin
            chk_fault_s = pop_sum_s[ADDR_W] | (pop_sum_s[ADDR_W-1:0] > SP_TOP);
        end else begin
            chk_fault_s = push_diff_s[ADDR_W] | (push_diff_s[ADDR_W-1:0] < SP_LIMIT);
        end
        case (op)
            OP_ADDSP: spop_res_s = sp_x_s + {1'b0, imm};
            OP_SUBSP: spop_res_s = sp_x_s - {1'b0, imm};
            default:  spop_res_s = {1'b0, imm};
        endcase
        spop_fault_s = (imm[WB_LOG2-1:0] != {WB_LOG2{1'b0}}) | spop_res_s[ADDR_W] |
                       (spop_res_s[ADDR_W-1:0] < SP_LIMIT) |
                       (spop_res_s[ADDR_W-1:0] > SP_TOP);
        rem_s = mask_r & ~({{(LW-1){1'b0}}, 1'b1} << cur_r);
    end

    // Sequencer next state: op dispatch, bound check, beat stepping, SP commit.
    always_comb begin
        state_s    = state_r;
        sp_s       = sp_r;
        spn_s      = spn_r;
        mask_s     = mask_r;
        pop_s      = pop_r;
        done_s     = 1'b0;
        fault_s    = 1'b0;
        beat_on_s  = 1'b0;
        beat_idx_s = cur_r;
        addr_s     = {ADDR_W{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_PUSH: begin
                            state_s = S_CHECK;
                            pop_s   = 1'b0;
                        end
                        OP_POP: begin
                            state_s = S_CHECK;
                            pop_s   = 1'b1;
                        end
                        OP_ADDSP, OP_SUBSP, OP_SETSP: begin
                            state_s = S_DONE;
                            done_s  = 1'b1;
                            fault_s = spop_fault_s;
                            sp_s    = spop_fault_s ? sp_r : spop_res_s[ADDR_W-1:0];
                        end
                        default: begin
                            state_s = S_DONE;
                            done_s  = 1'b1;
                            fault_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CHECK: begin
                if (chk_fault_s || (cnt_s == {CW{1'b0}})) begin
                    state_s = S_DONE;
                    done_s  = 1'b1;
                    fault_s = chk_fault_s;
                end else begin
                    state_s    = S_XFER;
                    mask_s     = reg_list;
                    beat_on_s  = 1'b1;
                    beat_idx_s = lowest(reg_list);
                    // PUSH fills upward from the new (lower) SP; POP reads upward from the old SP.
                    addr_s     = pop_r ? sp_r : push_diff_s[ADDR_W-1:0];
                    spn_s      = pop_r ? pop_sum_s[ADDR_W-1:0] : push_diff_s[ADDR_W-1:0];
                end
            end
            S_XFER: begin
                if (mem_ack) begin
                    if (rem_s == {LW{1'b0}}) begin
                        state_s = S_DONE;
                        done_s  = 1'b1;
                        sp_s    = spn_r;
                        mask_s  = {LW{1'b0}};
                    end else begin
                        mask_s     = rem_s;
                        beat_on_s  = 1'b1;
                        beat_idx_s = lowest(rem_s);
                        addr_s     = addr_r + WB_A;
                    end
                end else begin
                    beat_on_s  = 1'b1;
                    beat_idx_s = cur_r;
                    addr_s     = addr_r;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Per-beat register selection; the LR/PC slot has no RF address.
    always_comb begin
        is_lr_s = (beat_idx_s == LR_IDX);
        if (beat_on_s && !is_lr_s) begin
            rdest_s = beat_idx_s[REG_AW-1:0];
        end else begin
            rdest_s = {REG_AW{1'b0}};
        end
    end

    // State, SP and registered control outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
            sp_r    <= SP_TOP;
            spn_r   <= SP_TOP;
            mask_r  <= {LW{1'b0}};
            cur_r   <= {IW{1'b0}};
            pop_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fault_r <= 1'b0;
            force_r <= 1'b0;
            wr_r    <= 1'b0;
            rd_r    <= 1'b0;
            lr_r    <= 1'b0;
            rfw_r   <= 1'b0;
            pcw_r   <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            rdest_r <= {REG_AW{1'b0}};
        end else begin
            state_r <= state_s;
            sp_r    <= sp_s;
            spn_r   <= spn_s;
            mask_r  <= mask_s;
            cur_r   <= beat_idx_s;
            pop_r   <= pop_s;
            busy_r  <= (state_s != S_IDLE);
            done_r  <= done_s;
            fault_r <= fault_s;
            force_r <= beat_on_s;
            wr_r    <= beat_on_s & ~pop_s;
            rd_r    <= beat_on_s & pop_s;
            lr_r    <= beat_on_s & ~pop_s & is_lr_s;
            rfw_r   <= beat_on_s & pop_s & ~is_lr_s;
            pcw_r   <= beat_on_s & pop_s & is_lr_s;
            addr_r  <= addr_s;
            rdest_r <= rdest_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign fault      = fault_r;
    assign rdest_addr = rdest_r;
    assign LR_sel     = lr_r;
    assign dmem_addr  = addr_r;
    assign mem_force  = force_r;
    assign dmem_wr    = wr_r;
    assign dmem_rd    = rd_r;
    assign RF_wr      = rfw_r;
    assign PC_wr      = pcw_r;
    assign SP_out     = sp_r;

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Bench for stack_seq_ctrl: a transaction-level model expands each op into
// the expected per-cycle output trace; one compare process checks every cycle.
module tb_stack_seq_ctrl;

    localparam logic [15:0] TOP = 16'h0100;
    localparam logic [15:0] LIM = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, start, mem_ack;
    logic [2:0]  op;
    logic [8:0]  reg_list;
    logic [15:0] imm;
    logic        busy, done, fault, LR_sel, mem_force, dmem_wr, dmem_rd, RF_wr, PC_wr;
    logic [2:0]  rdest_addr;
    logic [15:0] dmem_addr, SP_out;

    logic        start_l, ack_l;
    logic [2:0]  op_l;
    logic [8:0]  list_l;
    logic [15:0] imm_l;
    logic        busy_l, done_l, fault_l, lrs_l, frc_l, wr_l, rd_l, rfw_l, pcw_l;
    logic [2:0]  rdest_l;
    logic [15:0] addr_l, sp_l;

    stack_seq_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .reg_list(reg_list),
        .imm(imm), .mem_ack(mem_ack), .busy(busy), .done(done), .fault(fault),
        .rdest_addr(rdest_addr), .LR_sel(LR_sel), .dmem_addr(dmem_addr),
        .mem_force(mem_force), .dmem_wr(dmem_wr), .dmem_rd(dmem_rd),
        .RF_wr(RF_wr), .PC_wr(PC_wr), .SP_out(SP_out)
    );

    stack_seq_ctrl #(.SP_LIMIT(16'h00F0)) dut_l (
        .clk(clk), .resetn(resetn), .start(start_l), .op(op_l), .reg_list(list_l),
        .imm(imm_l), .mem_ack(ack_l), .busy(busy_l), .done(done_l), .fault(fault_l),
        .rdest_addr(rdest_l), .LR_sel(lrs_l), .dmem_addr(addr_l),
        .mem_force(frc_l), .dmem_wr(wr_l), .dmem_rd(rd_l),
        .RF_wr(rfw_l), .PC_wr(pcw_l), .SP_out(sp_l)
    );

    typedef struct packed {
        logic        busy, done, fault, wr, rd, rfw, pcw, lrs, frc;
        logic [15:0] addr;
        logic [2:0]  rdst;
        logic        chk_addr, chk_rdst;
        logic [15:0] sp;
    } exp_t;

    typedef struct packed {
        exp_t        e;
        logic        st;
        logic [2:0]  op;
        logic [15:0] imm;
        logic        ack;
        logic        rst;
    } step_t;

    typedef struct packed {
        logic [15:0] a;
        logic [2:0]  r;
        logic        lr, rf, pc;
    } beat_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t_start = 0;
    int          t_done = 0;
    int          wr_cyc = 0;
    int          lim_t_done = 0;
    int          lim_wr = 0;
    logic        lim_fault = 1'b0;
    logic        last_fault = 1'b0;
    logic        chk_en = 1'b0;
    exp_t        exp_cur;
    logic [15:0] m_sp;
    beat_t       blog[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t e_idle(input logic [15:0] sp);
        exp_t e;
        e = '0;
        e.sp = sp;
        return e;
    endfunction

    function automatic exp_t e_reset();
        exp_t e;
        e = '0;
        e.chk_addr = 1'b1;
        e.chk_rdst = 1'b1;
        e.sp = TOP;
        return e;
    endfunction

    // Inputs that the DUT must ignore in this cycle get random values.
    function automatic step_t filler(input exp_t e);
        step_t s;
        s.e   = e;
        s.st  = 1'($urandom % 2);
        s.op  = 3'($urandom);
        s.imm = 16'($urandom);
        s.ack = 1'($urandom % 2);
        s.rst = 1'b0;
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process plus small logs used by the directed checks.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, exp_cur.busy);
            check("done", done, exp_cur.done);
            check("fault", fault, exp_cur.fault);
            check("dmem_wr", dmem_wr, exp_cur.wr);
            check("dmem_rd", dmem_rd, exp_cur.rd);
            check("RF_wr", RF_wr, exp_cur.rfw);
            check("PC_wr", PC_wr, exp_cur.pcw);
            check("LR_sel", LR_sel, exp_cur.lrs);
            check("mem_force", mem_force, exp_cur.frc);
            check("SP_out", SP_out, exp_cur.sp);
            if (exp_cur.chk_addr) check("dmem_addr", dmem_addr, exp_cur.addr);
            if (exp_cur.chk_rdst) check("rdest_addr", rdest_addr, exp_cur.rdst);
        end
        if (done) begin
            t_done <= cyc;
            last_fault <= fault;
        end
        if (dmem_wr) wr_cyc <= wr_cyc + 1;
        if ((dmem_wr || dmem_rd) && mem_ack)
            blog.push_back('{a: dmem_addr, r: rdest_addr, lr: LR_sel, rf: RF_wr, pc: PC_wr});
        if (done_l) begin
            lim_t_done <= cyc;
            lim_fault <= fault_l;
        end
        if (wr_l) lim_wr <= lim_wr + 1;
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        exp_cur = e_idle(m_sp);
        start   = 1'b0;
        mem_ack = 1'($urandom % 2);
        chk_en  = 1'b1;
    endtask

    // Expand one op into its expected cycle trace from the architectural rules, then play it.
    task automatic run_op(input logic [2:0] o, input logic [8:0] lst, input logic [15:0] im,
                          input int wfix, input int abort_k);
        step_t q[$];
        step_t s;
        exp_t  e;
        int    n, nsp, k, w;
        logic  f, ab;
        ab  = 1'b0;
        f   = 1'b0;
        nsp = int'(m_sp);
        s = filler(e_idle(m_sp));
        s.st = 1'b1; s.op = o; s.imm = im;
        q.push_back(s);
        e = e_idle(m_sp);
        e.busy = 1'b1;
        if (o == 3'd0 || o == 3'd1) begin
            q.push_back(filler(e));
            n = $countones(lst);
            if (o == 3'd0) begin
                nsp = int'(m_sp) - 4 * n;
                f = (nsp < int'(LIM));
            end else begin
                nsp = int'(m_sp) + 4 * n;
                f = (nsp > int'(TOP));
            end
            if (!f && n > 0) begin
                k = 0;
                for (int i = 0; i < 9; i++) begin
                    if (lst[i] && !ab) begin
                        w = (wfix >= 0) ? wfix : int'($urandom_range(2, 0));
                        for (int j = 0; j <= w && !ab; j++) begin
                            e = e_idle(m_sp);
                            e.busy = 1'b1; e.frc = 1'b1; e.chk_addr = 1'b1;
                            e.addr = 16'(((o == 3'd0) ? nsp : int'(m_sp)) + 4 * k);
                            e.wr  = (o == 3'd0);
                            e.rd  = (o == 3'd1);
                            e.lrs = (o == 3'd0) && (i == 8);
                            e.rfw = (o == 3'd1) && (i < 8);
                            e.pcw = (o == 3'd1) && (i == 8);
                            e.chk_rdst = (i < 8);
                            e.rdst = 3'(i);
                            s = filler(e);
                            s.ack = (j == w);
                            if (k == abort_k) begin
                                s.e = e_reset(); s.rst = 1'b1; s.ack = 1'b0; ab = 1'b1;
                            end
                            q.push_back(s);
                        end
                        k++;
                    end
                end
            end
        end else if (o <= 3'd4) begin
            if (o == 3'd2) nsp = int'(m_sp) + int'(im);
            else if (o == 3'd3) nsp = int'(m_sp) - int'(im);
            else nsp = int'(im);
            f = (im[1:0] != 2'd0) || (nsp < int'(LIM)) || (nsp > int'(TOP));
        end else begin
            f = 1'b1;
        end
        if (ab) begin
            s = filler(e_reset());
            s.st = 1'b0;
            q.push_back(s);
        end else begin
            e = e_idle(m_sp);
            e.busy = 1'b1; e.done = 1'b1; e.fault = f;
            e.sp = f ? m_sp : 16'(nsp);
            q.push_back(filler(e));
        end
        foreach (q[i]) begin
            @(posedge clk);
            #1;
            resetn  = !q[i].rst;
            exp_cur = q[i].e;
            start   = q[i].st;
            op      = q[i].op;
            imm     = q[i].imm;
            mem_ack = q[i].ack;
            chk_en  = 1'b1;
            if (i == 0) begin
                reg_list = lst;
                t_start  = cyc;
            end
        end
        m_sp = ab ? TOP : (f ? m_sp : 16'(nsp));
    endtask

    initial begin
        int snap, lim0;
        logic [2:0] ro;
        logic [8:0] rl;
        logic [15:0] ri;
        int r;
        resetn = 1'b0; start = 1'b0; op = 3'd0; reg_list = 9'd0; imm = 16'd0; mem_ack = 1'b0;
        start_l = 1'b0; op_l = 3'd0; list_l = 9'd0; imm_l = 16'd0; ack_l = 1'b1;
        m_sp = TOP;
        exp_cur = e_reset();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Limited-stack instance: SETSP 0xF4 then PUSH {R1,R3} must fault.
        start_l = 1'b1; op_l = 3'd4; imm_l = 16'h00F4;
        idle_cycle();
        start_l = 1'b0;
        idle_cycle();
        check("lim_setsp_sp", sp_l, 16'h00F4);
        start_l = 1'b1; op_l = 3'd0; list_l = 9'h00A;
        lim0 = cyc;
        snap = lim_wr;
        idle_cycle();
        start_l = 1'b0;
        repeat (3) idle_cycle();
        check("lim_done_latency", 32'(lim_t_done - lim0), 32'd2);
        check("lim_fault", lim_fault, 1'b1);
        check("lim_no_dmem_wr", 32'(lim_wr - snap), 32'd0);
        check("lim_sp_kept", sp_l, 16'h00F4);
        check("lim_busy_idle", busy_l, 1'b0);

        // PUSH {R0,R2,LR} from 0x100.
        blog.delete();
        run_op(3'd0, 9'h105, 16'd0, 0, -1);
        idle_cycle();
        check("push3_latency", 32'(t_done - t_start), 32'd5);
        check("push3_beats", blog.size(), 3);
        if (blog.size() == 3) begin
            check("push3_a0", blog[0].a, 16'h00F4);
            check("push3_a1", blog[1].a, 16'h00F8);
            check("push3_a2", blog[2].a, 16'h00FC);
            check("push3_lr0", blog[0].lr, 1'b0);
            check("push3_lr2", blog[2].lr, 1'b1);
        end
        check("push3_sp", SP_out, 16'h00F4);
        check("model_sp_push3", m_sp, 16'h00F4);

        // POP {R0,R2,PC} back to 0x100.
        blog.delete();
        run_op(3'd1, 9'h105, 16'd0, 0, -1);
        idle_cycle();
        check("pop3_beats", blog.size(), 3);
        if (blog.size() == 3) begin
            check("pop3_a0", blog[0].a, 16'h00F4);
            check("pop3_r0", blog[0].r, 3'd0);
            check("pop3_rf0", blog[0].rf, 1'b1);
            check("pop3_r1", blog[1].r, 3'd2);
            check("pop3_a2", blog[2].a, 16'h00FC);
            check("pop3_pc2", blog[2].pc, 1'b1);
            check("pop3_rf2", blog[2].rf, 1'b0);
        end
        check("pop3_sp", SP_out, 16'h0100);

        // PUSH {R5} with three wait cycles on the only beat.
        blog.delete();
        snap = wr_cyc;
        run_op(3'd0, 9'h020, 16'd0, 3, -1);
        idle_cycle();
        check("wait_wr_cycles", 32'(wr_cyc - snap), 32'd4);
        check("wait_latency", 32'(t_done - t_start), 32'd6);
        if (blog.size() == 1) check("wait_addr", blog[0].a, 16'h00FC);
        else check("wait_beats", blog.size(), 1);

        // SP op faults and a legal SETSP.
        run_op(3'd3, 16'h0006 == 16'h0006 ? 9'd0 : 9'd0, 16'h0006, 0, -1);
        idle_cycle();
        check("subsp_misaligned_fault", last_fault, 1'b1);
        check("subsp_sp_kept", SP_out, 16'h00FC);
        run_op(3'd4, 9'd0, 16'h0200, 0, -1);
        idle_cycle();
        check("setsp_bound_fault", last_fault, 1'b1);
        run_op(3'd4, 9'd0, 16'h0080, 0, -1);
        idle_cycle();
        check("setsp_ok_fault", last_fault, 1'b0);
        check("setsp_sp", SP_out, 16'h0080);

        // Reset during the second beat of a 4-register PUSH.
        blog.delete();
        run_op(3'd0, 9'h00F, 16'd0, 0, 1);
        idle_cycle();
        check("abort_beats_done", blog.size(), 1);
        check("abort_sp", SP_out, 16'h0100);
        check("abort_busy", busy, 1'b0);

        // Randomized operations.
        for (int t = 0; t < 250; t++) begin
            r  = int'($urandom_range(9, 0));
            rl = 9'($urandom);
            if ($urandom_range(7, 0) == 0) rl = 9'd0;
            ri = 16'($urandom_range(20, 0) * 4);
            if (r <= 2) ro = 3'd0;
            else if (r <= 5) ro = 3'd1;
            else if (r == 6) ro = 3'd2;
            else if (r == 7) ro = 3'd3;
            else if (r == 8) begin
                ro = 3'd4;
                ri = 16'($urandom_range(66, 0) * 4);
            end else ro = 3'(5 + $urandom_range(2, 0));
            if ($urandom_range(7, 0) == 0) ri = ri | 16'h0002;
            run_op(ro, rl, ri, -1, -1);
        end
        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
